// File: rtl/acc.sv
// Frame statistics accumulator.
// Collects count, saturating sum, min and max of the samples in each frame.
// A frame is bracketed by the falling and rising edges of IN_DONE.
// The result set is latched once at frame end and flagged with a one-cycle
// RESULT_VALID pulse.
module acc #(
  parameter int DATA_WIDTH = 16,
  parameter int SUM_WIDTH  = 48,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_DONE,
  output logic                  BUSY,
  output logic                  RESULT_VALID,
  output logic [CNT_WIDTH-1:0]  RES_CNT,
  output logic [SUM_WIDTH-1:0]  RES_SUM,
  output logic [DATA_WIDTH-1:0] RES_MIN,
  output logic [DATA_WIDTH-1:0] RES_MAX,
  output logic                  RES_OVF
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_RUN   = 3'b010,
    S_LATCH = 3'b100
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic                    done_d_r;
  logic                    start_s;
  logic                    end_s;

  logic [CNT_WIDTH-1:0]    cnt_r;
  logic [SUM_WIDTH-1:0]    sum_r;
  logic [DATA_WIDTH-1:0]   min_r;
  logic [DATA_WIDTH-1:0]   max_r;
  logic                    ovf_r;

  logic [CNT_WIDTH-1:0]    cnt_s;
  logic [SUM_WIDTH-1:0]    sum_s;
  logic [DATA_WIDTH-1:0]   min_s;
  logic [DATA_WIDTH-1:0]   max_s;
  logic                    ovf_s;
  logic [SUM_WIDTH:0]      sum_add_s;

  logic                    busy_r;
  logic                    result_valid_r;
  logic [CNT_WIDTH-1:0]    res_cnt_r;
  logic [SUM_WIDTH-1:0]    res_sum_r;
  logic [DATA_WIDTH-1:0]   res_min_r;
  logic [DATA_WIDTH-1:0]   res_max_r;
  logic                    res_ovf_r;

  // Frame boundaries come from the edges of the upstream done level.
  assign start_s = done_d_r & ~IN_DONE;
  assign end_s   = ~done_d_r & IN_DONE;

  // Delayed copy of IN_DONE for edge detection; idles high like the upstream flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_d_r <= 1'b1;
    end else begin
      done_d_r <= IN_DONE;
    end
  end

  // State register; any non-one-hot value falls back to idle through next-state logic.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: idle -> run on start, run -> latch on end, latch -> idle.
  always_comb begin
    state_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (start_s) begin
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (end_s) begin
          state_s = S_LATCH;
        end else begin
          state_s = S_RUN;
        end
      end
      S_LATCH: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Accumulator values after accepting the current sample, with saturation.
  always_comb begin
    sum_add_s = {1'b0, sum_r} + {{(SUM_WIDTH + 1 - DATA_WIDTH){1'b0}}, IN_DATA};
    ovf_s     = ovf_r;
    if (&cnt_r) begin
      cnt_s = cnt_r;
    end else begin
      cnt_s = cnt_r + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
    end
    if (&cnt_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_s;
    end
    if (sum_add_s[SUM_WIDTH]) begin
      sum_s = {SUM_WIDTH{1'b1}};
      ovf_s = 1'b1;
    end else begin
      sum_s = sum_add_s[SUM_WIDTH-1:0];
    end
    if (IN_DATA < min_r) begin
      min_s = IN_DATA;
    end else begin
      min_s = min_r;
    end
    if (IN_DATA > max_r) begin
      max_s = IN_DATA;
    end else begin
      max_s = max_r;
    end
  end

  // Accumulators: cleared at frame start, updated per accepted sample in run.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CNT_WIDTH{1'b0}};
      sum_r <= {SUM_WIDTH{1'b0}};
      min_r <= {DATA_WIDTH{1'b0}};
      max_r <= {DATA_WIDTH{1'b0}};
      ovf_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
            sum_r <= {SUM_WIDTH{1'b0}};
            min_r <= {DATA_WIDTH{1'b1}};
            max_r <= {DATA_WIDTH{1'b0}};
            ovf_r <= 1'b0;
          end
        end
        S_RUN: begin
          if (IN_VALID) begin
            cnt_r <= cnt_s;
            sum_r <= sum_s;
            min_r <= min_s;
            max_r <= max_s;
            ovf_r <= ovf_s;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Busy flag registered from the next state so it tracks the run state exactly.
  always_ff @(posedge CLK) begin
    if (RST) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_s == S_RUN);
    end
  end

  // Result set: captured once in the latch state and held until the next frame end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      result_valid_r <= 1'b0;
      res_cnt_r      <= {CNT_WIDTH{1'b0}};
      res_sum_r      <= {SUM_WIDTH{1'b0}};
      res_min_r      <= {DATA_WIDTH{1'b0}};
      res_max_r      <= {DATA_WIDTH{1'b0}};
      res_ovf_r      <= 1'b0;
    end else if (state_r == S_LATCH) begin
      result_valid_r <= 1'b1;
      res_cnt_r      <= cnt_r;
      res_sum_r      <= sum_r;
      res_ovf_r      <= ovf_r;
      if (cnt_r == {CNT_WIDTH{1'b0}}) begin
        res_min_r <= {DATA_WIDTH{1'b0}};
        res_max_r <= {DATA_WIDTH{1'b0}};
      end else begin
        res_min_r <= min_r;
        res_max_r <= max_r;
      end
    end else begin
      result_valid_r <= 1'b0;
    end
  end

  assign BUSY         = busy_r;
  assign RESULT_VALID = result_valid_r;
  assign RES_CNT      = res_cnt_r;
  assign RES_SUM      = res_sum_r;
  assign RES_MIN      = res_min_r;
  assign RES_MAX      = res_max_r;
  assign RES_OVF      = res_ovf_r;

endmodule

// File: tb/tb_acc.sv
// Bench for acc: directed frames plus random frames.
// Two instances are driven with identical stimulus, one with the default
// 48-bit sum and one with a 17-bit sum to exercise saturation.
// Expected results come from a frame-level model over the accepted samples.
module tb_acc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_done;

  logic        a_busy, a_rv, a_ovf;
  logic [31:0] a_cnt;
  logic [47:0] a_sum;
  logic [15:0] a_min, a_max;

  logic        b_busy, b_rv, b_ovf;
  logic [31:0] b_cnt;
  logic [16:0] b_sum;
  logic [15:0] b_min, b_max;

  int n_checks = 0;
  int n_errors = 0;

  logic        stim_v[$];
  logic [15:0] stim_d[$];
  int          acc_q[$];

  always #5 CLK = ~CLK;

  acc dut_a (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_DONE(in_done),
    .BUSY(a_busy), .RESULT_VALID(a_rv), .RES_CNT(a_cnt), .RES_SUM(a_sum),
    .RES_MIN(a_min), .RES_MAX(a_max), .RES_OVF(a_ovf)
  );

  acc #(.SUM_WIDTH(17)) dut_b (
    .CLK(CLK), .RST(RST), .IN_VALID(in_valid), .IN_DATA(in_data), .IN_DONE(in_done),
    .BUSY(b_busy), .RESULT_VALID(b_rv), .RES_CNT(b_cnt), .RES_SUM(b_sum),
    .RES_MIN(b_min), .RES_MAX(b_max), .RES_OVF(b_ovf)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic done);
    in_valid = v;
    in_data  = d;
    in_done  = done;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic v, input logic [15:0] d);
    stim_v.push_back(v);
    stim_d.push_back(d);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_busy"}, 64'(a_busy), 64'd0);
    check({tag, "_a_rv"},   64'(a_rv),   64'd0);
    check({tag, "_a_cnt"},  64'(a_cnt),  64'd0);
    check({tag, "_a_sum"},  64'(a_sum),  64'd0);
    check({tag, "_a_min"},  64'(a_min),  64'd0);
    check({tag, "_a_max"},  64'(a_max),  64'd0);
    check({tag, "_a_ovf"},  64'(a_ovf),  64'd0);
    check({tag, "_b_busy"}, 64'(b_busy), 64'd0);
    check({tag, "_b_rv"},   64'(b_rv),   64'd0);
    check({tag, "_b_sum"},  64'(b_sum),  64'd0);
    check({tag, "_b_ovf"},  64'(b_ovf),  64'd0);
  endtask

  // Frame-level model: count, plain sum, min and max of the accepted samples.
  task automatic check_results(input string tag);
    longint s;
    longint lim_a;
    longint lim_b;
    int     mn;
    int     mx;
    s  = 0;
    mn = 65535;
    mx = 0;
    foreach (acc_q[i]) begin
      s = s + longint'(acc_q[i]);
      if (acc_q[i] < mn) mn = acc_q[i];
      if (acc_q[i] > mx) mx = acc_q[i];
    end
    if (acc_q.size() == 0) begin
      mn = 0;
      mx = 0;
    end
    lim_a = (longint'(1) <<< 48) - 1;
    lim_b = (longint'(1) <<< 17) - 1;
    check({tag, "_a_cnt"}, 64'(a_cnt), 64'(acc_q.size()));
    check({tag, "_a_sum"}, 64'(a_sum), 64'((s > lim_a) ? lim_a : s));
    check({tag, "_a_min"}, 64'(a_min), 64'(mn));
    check({tag, "_a_max"}, 64'(a_max), 64'(mx));
    check({tag, "_a_ovf"}, 64'(a_ovf), 64'(s > lim_a));
    check({tag, "_b_cnt"}, 64'(b_cnt), 64'(acc_q.size()));
    check({tag, "_b_sum"}, 64'(b_sum), 64'((s > lim_b) ? lim_b : s));
    check({tag, "_b_min"}, 64'(b_min), 64'(mn));
    check({tag, "_b_max"}, 64'(b_max), 64'(mx));
    check({tag, "_b_ovf"}, 64'(b_ovf), 64'(s > lim_b));
  endtask

  // Runs one frame from stim_v/stim_d; the last entry is the IN_DONE-rising cycle.
  task automatic run_frame(input string tag);
    int n;
    n = stim_v.size();
    acc_q.delete();
    // Start cycle: any sample here lies before the frame and must be ignored.
    drive(1'($urandom), 16'($urandom), 1'b0);
    tick();
    check({tag, "_busy_start"}, 64'(a_busy), 64'd1);
    check({tag, "_rv_start"},   64'(a_rv),   64'd0);
    for (int i = 0; i < n; i++) begin
      drive(stim_v[i], stim_d[i], (i == n - 1));
      if (stim_v[i]) acc_q.push_back(int'(stim_d[i]));
      tick();
      if (i != n - 1) check({tag, "_busy_run"}, 64'(b_busy), 64'd1);
    end
    check({tag, "_rv_early"}, 64'(a_rv), 64'd0);
    drive(1'($urandom), 16'($urandom), 1'b1);
    tick();
    check({tag, "_a_rv"},   64'(a_rv),   64'd1);
    check({tag, "_b_rv"},   64'(b_rv),   64'd1);
    check({tag, "_busy_end"}, 64'(a_busy), 64'd0);
    check_results(tag);
    drive(1'($urandom), 16'($urandom), 1'b1);
    tick();
    check({tag, "_rv_drop"}, 64'(a_rv), 64'd0);
    check_results({tag, "_hold"});
    stim_v.delete();
    stim_d.delete();
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 16'd0, 1'b1);
    tick();
    tick();
    RST = 1'b0;
    tick();
    check_zero("reset");

    // Samples while idle are ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'($urandom), 1'b1);
      tick();
    end
    check_zero("idle_valid");

    push(1'b1, 16'd5); push(1'b1, 16'd3); push(1'b1, 16'd9); push(1'b1, 16'd1);
    push(1'b0, 16'd0);
    run_frame("basic");

    push(1'b0, 16'd0); push(1'b0, 16'd0); push(1'b0, 16'd0);
    run_frame("empty");

    push(1'b0, 16'd0);
    run_frame("min_frame");

    push(1'b1, 16'd4); push(1'b1, 16'd7);
    run_frame("last_in_end");

    push(1'b1, 16'hFFFF); push(1'b1, 16'hFFFF); push(1'b1, 16'hFFFF); push(1'b1, 16'hFFFF);
    push(1'b0, 16'd0);
    run_frame("sat");

    push(1'b1, 16'd2); push(1'b1, 16'd8);
    run_frame("after_sat");

    // Reset in the middle of a frame discards it.
    drive(1'b0, 16'd0, 1'b0);
    tick();
    drive(1'b1, 16'd11, 1'b0);
    tick();
    drive(1'b1, 16'd12, 1'b0);
    tick();
    RST = 1'b1;
    drive(1'b0, 16'd0, 1'b1);
    tick();
    RST = 1'b0;
    tick();
    check_zero("mid_rst");
    tick();
    check_zero("mid_rst2");

    push(1'b1, 16'd10); push(1'b1, 16'd20); push(1'b0, 16'd0);
    run_frame("post_rst");

    // Random frames with random gaps, validity and occasional full-scale data.
    for (int f = 0; f < 25; f++) begin
      int len;
      int gap;
      len = int'($urandom_range(1, 24));
      for (int i = 0; i < len; i++) begin
        push(($urandom % 4) != 0, (($urandom % 5) == 0) ? 16'hFFFF : 16'($urandom));
      end
      run_frame("rand");
      gap = int'($urandom_range(0, 2));
      for (int i = 0; i < gap; i++) begin
        drive(1'($urandom), 16'($urandom), 1'b1);
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
